scalar_mult_ctrl: RTL and testbench
===================================

Name: scalar_mult_ctrl

Overview:
- Left-to-right double-and-add sequencer for ECC scalar multiplication Q = k·P.
- Owns the accumulator point Q and the bit index.
- Issues one-cycle start pulses to one external point-doubling unit and one external point-addition unit, then captures their results on a done pulse.
- Sits between the top-level scalar-mult request interface and the two point-arithmetic datapaths.

Parameters:
- N, 231, field element / coordinate width in bits.
- K, 231, scalar width in bits.
- TIMEOUT, 65535, maximum cycles to wait for an operation done pulse before abort (must be less than 2^20).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- k  in  K  scalar; captured on accepted start.
- px, py  in  N  base point P; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the result is valid.
- err  out  1  high together with done when an operation timed out.
- qx, qy  out  N  result coordinates; held until the next accepted start.
- q_inf  out  1  result is the point at infinity.
- dbl_start  out  1  one-cycle pulse; the doubling unit operates on dbl_x/dbl_y.
- dbl_x, dbl_y  out  N  doubling operand (current Q).
- dbl_done  in  1  doubling result valid pulse.
- dbl_rx, dbl_ry  in  N  doubling result.
- dbl_rinf  in  1  doubling result is infinity.
- add_start  out  1  one-cycle pulse; operands are Q (add_x1/add_y1) and P (add_x2/add_y2).
- add_x1, add_y1, add_x2, add_y2  out  N  addition operands.
- add_done, add_rx, add_ry, add_rinf  in  1/N/N/1  addition result handshake and data, same semantics as the doubling port.

Behaviour:
- Reset values:
  - State = IDLE.
  - busy, done, err, dbl_start, add_start = 0.
  - qx, qy = 0; q_inf = 1.
  - Bit index and watchdog counter = 0.
- Reset mid-operation aborts immediately. No done pulse is produced. Late done pulses arriving after reset are ignored, because they are only honoured in WAIT states.
- FSM states:
  - IDLE: on start, capture k, px, py, set index = K-1, set Q = infinity, go to SCAN. start is ignored in every other state.
  - SCAN: one bit per cycle.
    - Q is infinity and k[index] = 0: decrement index.
    - Q is infinity and k[index] = 1: Q = P with no operation issued (leading-one shortcut), then go to NEXT.
    - Index underflows with Q still infinity (k = 0): go to FIN.
  - NEXT: if index = 0, go to FIN. Otherwise decrement index and go to DBL_REQ.
  - DBL_REQ: assert dbl_start for exactly one cycle with operands = Q; clear the watchdog; go to DBL_WAIT.
  - DBL_WAIT: on dbl_done, Q = (dbl_rx, dbl_ry, dbl_rinf).
    - If k[index] = 1, go to ADD_REQ; otherwise go to NEXT.
    - If Q became infinity and k[index] = 1, skip the add: set Q = P and go to NEXT.
  - ADD_REQ / ADD_WAIT: same handshake as doubling, using add_* ports. On add_done, capture the result and go to NEXT.
  - FIN: copy Q to qx/qy/q_inf, pulse done for one cycle, drop busy, return to IDLE.
- Watchdog:
  - Counts cycles in each WAIT state.
  - On reaching TIMEOUT: err = 1, q_inf = 1, qx = qy = 0, pulse done, return to IDLE.
  - err stays high until the next accepted start.
- Handshake rules:
  - A done pulse in the same cycle as the corresponding start pulse is ignored; the unit must respond at least one cycle after start.
  - Operand outputs are held stable from the start pulse through the done pulse.
  - Spurious done pulses outside the matching WAIT state are ignored.
- Latency:
  - start to first SCAN: 1 cycle.
  - With the leading one at bit j: (K-1-j) + 1 scan cycles, then per remaining bit 1 NEXT + 1 REQ + unit latency, plus an add round when the bit is 1; then 1 FIN cycle.
  - k = 0: done arrives K+2 cycles after start.
- Only one arithmetic operation is outstanding at any time. dbl_start and add_start are never high together.

Decomposition:
- Package ecc_pkg holds:
  - State enum (IDLE, SCAN, NEXT, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, FIN).
  - A point struct {x, y, inf} parameterised by N.
  - The TIMEOUT default.
- One sub-module, op_watchdog: a counter with clear/enable inputs and an expired output, instantiated once and shared by both WAIT states.

Test Plan:
- Use stub units with a fixed 5-cycle latency that return fixed coordinates.
- k=0: done after exactly K+2 cycles, q_inf=1, zero dbl_start/add_start pulses.
- k=1: no unit pulses; qx/qy = px/py; q_inf=0; busy deasserts in the same cycle done pulses.
- k=5 (binary 101): pulse order dbl, dbl, add. Result equals the add stub's output, which the stub checks was presented operands Q=2(2P) and P.
- Stub doubling never asserts dbl_done: done and err both high exactly TIMEOUT+1 cycles after dbl_start, result infinity, next start clears err.
- reset asserted during ADD_WAIT, stub then asserts add_done: no done pulse, outputs at reset values, busy=0.
- start re-pulsed while busy, plus a dbl_done injected during ADD_WAIT: both ignored, result unchanged from the undisturbed run.

Source files
------------

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared state encoding, point type and defaults for the ECC scalar-mult controller
package ecc_pkg;

  localparam int unsigned ECC_N       = 231;
  localparam int unsigned ECC_K       = 231;
  localparam int unsigned ECC_TIMEOUT = 65535;
  localparam int unsigned WD_CW       = 20;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    NEXT,
    DBL_REQ,
    DBL_WAIT,
    ADD_REQ,
    ADD_WAIT,
    FIN
  } sm_state_t;

  // Affine point plus an explicit point-at-infinity flag; coordinates are ECC_N wide,
  // so the controller must be built with N equal to ECC_N.
  typedef struct packed {
    logic [ECC_N-1:0] x;
    logic [ECC_N-1:0] y;
    logic             inf;
  } point_t;

  localparam point_t POINT_INF = '{x: '0, y: '0, inf: 1'b1};

endpackage

// File: rtl/op_watchdog.sv
// op_watchdog: counts cycles spent waiting on a point unit and flags when the limit is hit
module op_watchdog
  import ecc_pkg::*;
#(
  parameter int unsigned TIMEOUT = ECC_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WD_CW-1:0] count;

  assign expired = (count == WD_CW'(TIMEOUT));

  // Wait-cycle counter; it saturates at the limit so expired stays high until cleared
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/scalar_mult_ctrl.sv
// scalar_mult_ctrl: left-to-right double-and-add sequencer driving external point units
module scalar_mult_ctrl
  import ecc_pkg::*;
#(
  parameter int unsigned N       = ECC_N,
  parameter int unsigned K       = ECC_K,
  parameter int unsigned TIMEOUT = ECC_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [K-1:0] k,
  input  logic [N-1:0] px,
  input  logic [N-1:0] py,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] qx,
  output logic [N-1:0] qy,
  output logic         q_inf,
  output logic         dbl_start,
  output logic [N-1:0] dbl_x,
  output logic [N-1:0] dbl_y,
  input  logic         dbl_done,
  input  logic [N-1:0] dbl_rx,
  input  logic [N-1:0] dbl_ry,
  input  logic         dbl_rinf,
  output logic         add_start,
  output logic [N-1:0] add_x1,
  output logic [N-1:0] add_y1,
  output logic [N-1:0] add_x2,
  output logic [N-1:0] add_y2,
  input  logic         add_done,
  input  logic [N-1:0] add_rx,
  input  logic [N-1:0] add_ry,
  input  logic         add_rinf
);

  localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(K - 1);

  sm_state_t     state;
  logic [K-1:0]  k_r;
  logic [IW-1:0] idx;
  point_t        p_r;
  point_t        q_r;
  logic          wd_clear;
  logic          wd_enable;
  logic          wd_expired;

  // Operands come straight from the Q and P registers, which only change on a
  // captured result or an accepted start, so they stay put while a unit works.
  assign dbl_x  = q_r.x;
  assign dbl_y  = q_r.y;
  assign add_x1 = q_r.x;
  assign add_y1 = q_r.y;
  assign add_x2 = p_r.x;
  assign add_y2 = p_r.y;

  assign wd_clear  = (state == DBL_REQ) || (state == ADD_REQ);
  assign wd_enable = (state == DBL_WAIT) || (state == ADD_WAIT);

  op_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // Main sequencer: scans for the leading one, then one double (and optional add) per bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      dbl_start <= 1'b0;
      add_start <= 1'b0;
      qx        <= '0;
      qy        <= '0;
      q_inf     <= 1'b1;
      idx       <= '0;
      k_r       <= '0;
      p_r       <= '0;
      q_r       <= POINT_INF;
    end else begin
      done      <= 1'b0;
      dbl_start <= 1'b0;
      add_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_r   <= k;
            p_r   <= '{x: px, y: py, inf: 1'b0};
            q_r   <= POINT_INF;
            idx   <= IDX_TOP;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (k_r[idx]) begin
            q_r   <= p_r;
            state <= NEXT;
          end else if (idx == '0) begin
            state <= FIN;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        NEXT: begin
          if (idx == '0) begin
            state <= FIN;
          end else begin
            idx   <= idx - 1'b1;
            state <= DBL_REQ;
          end
        end
        DBL_REQ: begin
          dbl_start <= 1'b1;
          state     <= DBL_WAIT;
        end
        DBL_WAIT: begin
          if (dbl_done && !dbl_start) begin
            if (k_r[idx] && dbl_rinf) begin
              q_r   <= p_r;
              state <= NEXT;
            end else begin
              q_r   <= '{x: dbl_rx, y: dbl_ry, inf: dbl_rinf};
              state <= k_r[idx] ? ADD_REQ : NEXT;
            end
          end else if (wd_expired) begin
            qx    <= '0;
            qy    <= '0;
            q_inf <= 1'b1;
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        ADD_REQ: begin
          add_start <= 1'b1;
          state     <= ADD_WAIT;
        end
        ADD_WAIT: begin
          if (add_done && !add_start) begin
            q_r   <= '{x: add_rx, y: add_ry, inf: add_rinf};
            state <= NEXT;
          end else if (wd_expired) begin
            qx    <= '0;
            qy    <= '0;
            q_inf <= 1'b1;
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        FIN: begin
          qx    <= q_r.x;
          qy    <= q_r.y;
          q_inf <= q_r.inf;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// tb_scalar_mult_ctrl: scoreboard bench with linear-group point-unit stubs
module tb_scalar_mult_ctrl;

  localparam int N       = 231;
  localparam int K       = 231;
  localparam int TIMEOUT = 300;
  localparam int LAT     = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [K-1:0] k;
  logic [N-1:0] px, py;
  logic         busy, done, err, q_inf;
  logic [N-1:0] qx, qy;
  logic         dbl_start, dbl_done, dbl_rinf;
  logic [N-1:0] dbl_x, dbl_y, dbl_rx, dbl_ry;
  logic         add_start, add_done, add_rinf;
  logic [N-1:0] add_x1, add_y1, add_x2, add_y2, add_rx, add_ry;

  // Stubs model points as multiples m*P of a linear group mod 2^N: point m*P has
  // coordinates (m*px, m*py), so doubling doubles them and adding sums them.
  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         inf;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int start_cyc    = 0;
  int done_cyc     = 0;
  int dbl_start_cyc = 0;
  int dbl_pulses   = 0;
  int add_pulses   = 0;
  int exp_dbl      = 0;
  int exp_add      = 0;
  int dbl_pend     = 0;
  int add_pend     = 0;
  int inj_pend     = 0;
  bit dbl_hang     = 1'b0;
  bit inj_dbl      = 1'b0;
  bit add_orphan   = 1'b0;
  logic [N-1:0] cur_px, cur_py;
  logic [N-1:0] dbl_cx, dbl_cy, add_cx1, add_cy1, add_cx2, add_cy2;

  scalar_mult_ctrl #(
    .N(N), .K(K), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .k(k), .px(px), .py(py),
    .busy(busy), .done(done), .err(err), .qx(qx), .qy(qy), .q_inf(q_inf),
    .dbl_start(dbl_start), .dbl_x(dbl_x), .dbl_y(dbl_y), .dbl_done(dbl_done),
    .dbl_rx(dbl_rx), .dbl_ry(dbl_ry), .dbl_rinf(dbl_rinf),
    .add_start(add_start), .add_x1(add_x1), .add_y1(add_y1), .add_x2(add_x2),
    .add_y2(add_y2), .add_done(add_done), .add_rx(add_rx), .add_ry(add_ry),
    .add_rinf(add_rinf)
  );

  always #5 clk = ~clk;

  // Free-running cycle index used for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] randWide();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[N-1:0];
  endfunction

  function automatic int msbPos(input logic [K-1:0] kv);
    for (int i = K - 1; i >= 0; i--) if (kv[i]) return i;
    return 0;
  endfunction

  // Doubling stub: fixed latency, result is the doubled operand, checks operand stability
  initial begin
    dbl_done = 1'b0; dbl_rx = '0; dbl_ry = '0; dbl_rinf = 1'b0;
    forever begin
      @(posedge clk); #1;
      dbl_done = 1'b0;
      if (dbl_pend > 0) begin
        dbl_pend--;
        if (dbl_pend == 0) begin
          checkOutput("dbl_x held", dbl_x, dbl_cx);
          checkOutput("dbl_y held", dbl_y, dbl_cy);
          dbl_rx = dbl_cx << 1; dbl_ry = dbl_cy << 1; dbl_rinf = 1'b0; dbl_done = 1'b1;
        end
      end
      if (inj_pend > 0) begin
        inj_pend--;
        if (inj_pend == 0) begin
          dbl_rx = randWide(); dbl_ry = randWide(); dbl_rinf = 1'($urandom_range(0, 1));
          dbl_done = 1'b1;
        end
      end
      if (inj_dbl && add_start === 1'b1) inj_pend = 2;
      if (dbl_start === 1'b1) begin
        dbl_cx = dbl_x; dbl_cy = dbl_y; dbl_start_cyc = cyc;
        if (!dbl_hang) dbl_pend = LAT;
      end
    end
  end

  // Addition stub: fixed latency, result is the coordinate sum, checks the P operand
  initial begin
    add_done = 1'b0; add_rx = '0; add_ry = '0; add_rinf = 1'b0;
    forever begin
      @(posedge clk); #1;
      add_done = 1'b0;
      if (add_pend > 0) begin
        add_pend--;
        if (add_pend == 0) begin
          if (!add_orphan) begin
            checkOutput("add_x1 held", add_x1, add_cx1);
            checkOutput("add_y1 held", add_y1, add_cy1);
          end
          add_rx = add_cx1 + add_cx2; add_ry = add_cy1 + add_cy2; add_rinf = 1'b0; add_done = 1'b1;
        end
      end
      if (add_start === 1'b1) begin
        checkOutput("add_x2 is P", add_x2, cur_px);
        checkOutput("add_y2 is P", add_y2, cur_py);
        add_cx1 = add_x1; add_cy1 = add_y1; add_cx2 = add_x2; add_cy2 = add_y2;
        add_orphan = 1'b0;
        add_pend = LAT;
      end
    end
  end

  // Monitor: counts unit pulses and checks every presented result against the scoreboard
  always @(negedge clk) begin
    if (dbl_start === 1'b1) dbl_pulses++;
    if (add_start === 1'b1) add_pulses++;
    if (dbl_start === 1'b1 || add_start === 1'b1)
      checkOutput("single op issue", N'(dbl_start & add_start), N'(0));
    if (done === 1'b1) begin
      done_cyc = cyc;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected done: got done=1, expected none at cycle %0d", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("result qx", qx, mon_e.x);
        checkOutput("result qy", qy, mon_e.y);
        checkOutput("result q_inf", N'(q_inf), N'(mon_e.inf));
        checkOutput("result err", N'(err), N'(mon_e.err));
        checkOutput("busy low at done", N'(busy), N'(0));
      end
    end
  end

  task automatic applyStimulus(input logic [K-1:0] kv, input logic [N-1:0] pxv,
                               input logic [N-1:0] pyv, input bit expect_result);
    exp_t e;
    cur_px = pxv;
    cur_py = pyv;
    e.x   = kv * pxv;
    e.y   = kv * pyv;
    e.inf = (kv == '0);
    e.err = 1'b0;
    if (expect_result) exp_q.push_back(e);
    exp_dbl = (kv == '0) ? 0 : msbPos(kv);
    exp_add = (kv == '0) ? 0 : $countones(kv) - 1;
    dbl_pulses = 0;
    add_pulses = 0;
    @(posedge clk); #1;
    start = 1'b1; k = kv; px = pxv; py = pyv; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, N'(busy), N'(0));
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic checkCounts(input string tag);
    checkOutput({tag, " dbl pulses"}, N'(dbl_pulses), N'(exp_dbl));
    checkOutput({tag, " add pulses"}, N'(add_pulses), N'(exp_add));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic [N-1:0] rx, ry;
    logic [K-1:0] rk;
    int n;
    reset = 1'b1; start = 1'b0; k = '0; px = '0; py = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("reset busy", N'(busy), N'(0));
    checkOutput("reset done", N'(done), N'(0));
    checkOutput("reset err", N'(err), N'(0));
    checkOutput("reset q_inf", N'(q_inf), N'(1));
    checkOutput("reset qx", qx, '0);
    checkOutput("reset qy", qy, '0);
    checkOutput("reset dbl_start", N'(dbl_start), N'(0));
    checkOutput("reset add_start", N'(add_start), N'(0));

    rx = randWide() | 1; ry = randWide();
    applyStimulus('0, rx, ry, 1'b1);
    waitIdle(K + 20, "k0 completes");
    checkOutput("k0 latency", N'(done_cyc - start_cyc), N'(K + 2));
    checkCounts("k0");

    rx = randWide() | 1; ry = randWide();
    applyStimulus(K'(1), rx, ry, 1'b1);
    waitIdle(K + 20, "k1 completes");
    checkCounts("k1");

    rx = randWide() | 1; ry = randWide();
    applyStimulus(K'(5), rx, ry, 1'b1);
    waitIdle(K + 100, "k5 completes");
    checkCounts("k5");

    $display("[TB] timeout scenario");
    dbl_hang = 1'b1;
    rx = randWide() | 1; ry = randWide();
    applyStimulus(K'(2), rx, ry, 1'b0);
    exp_q.push_back('{x: '0, y: '0, inf: 1'b1, err: 1'b1});
    waitIdle(K + TIMEOUT + 50, "timeout completes");
    checkOutput("timeout latency", N'(done_cyc - dbl_start_cyc), N'(TIMEOUT + 1));
    dbl_hang = 1'b0;

    rx = randWide() | 1; ry = randWide();
    applyStimulus(K'(1), rx, ry, 1'b1);
    checkOutput("err cleared by start", N'(err), N'(0));
    checkOutput("busy after start", N'(busy), N'(1));
    waitIdle(K + 20, "post-timeout completes");

    $display("[TB] reset during add wait");
    rx = randWide() | 1; ry = randWide();
    applyStimulus(K'(3), rx, ry, 1'b0);
    n = 0;
    while (add_start !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("add_start seen", N'(add_start), N'(1));
    @(posedge clk); #1;
    add_orphan = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("post-reset busy", N'(busy), N'(0));
    checkOutput("post-reset q_inf", N'(q_inf), N'(1));
    checkOutput("post-reset qx", qx, '0);
    checkOutput("post-reset qy", qy, '0);
    checkOutput("post-reset err", N'(err), N'(0));

    $display("[TB] disturbed run");
    rx = randWide() | 1; ry = randWide();
    rk = K'($urandom_range(1024, 65535));
    inj_dbl = 1'b1;
    applyStimulus(rk, rx, ry, 1'b1);
    repeat (250) @(posedge clk);
    #1;
    start = 1'b1; k = randWide(); px = randWide(); py = randWide();
    @(posedge clk); #1;
    start = 1'b0;
    waitIdle(3000, "disturbed completes");
    inj_dbl = 1'b0;
    checkCounts("disturbed");

    for (int i = 0; i < 10; i++) begin
      rx = randWide() | 1; ry = randWide();
      rk = (i < 4) ? randWide() : K'($urandom_range(2, 65535));
      applyStimulus(rk, rx, ry, 1'b1);
      waitIdle(6000, "random completes");
      checkCounts("random");
    end

    checkOutput("scoreboard drained", N'(exp_q.size()), N'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
